// File: rtl/ball_pkg.sv
// Shared types, geometry and colour constants for the jumping-ball engine.
package ball_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    typedef logic signed [10:0] coord_t;
    typedef logic signed [5:0]  vel_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        vel_t   vx;
        vel_t   vy;
    } ball_t;

    localparam int H_ACT       = 640;
    localparam int V_ACT       = 480;
    localparam int BALL_SZ     = 12;
    localparam int PAD_W       = 80;
    localparam int PAD_H       = 8;
    localparam int PAD_Y       = 460;
    localparam int PAD_STEP    = 6;
    localparam int GRAV        = 1;
    localparam int VMAX        = 15;
    localparam int JUMP_V      = 14;
    localparam int VX0         = 3;
    localparam int OVER_FRAMES = 120;

    localparam logic [11:0] BG      = 12'h000;
    localparam logic [11:0] BG_OVER = 12'h400;
    localparam logic [11:0] BALL    = 12'hFF0;
    localparam logic [11:0] PAD     = 12'h0FF;
    localparam logic [11:0] BAR     = 12'h0F0;

    localparam coord_t C_BALL_SZ  = coord_t'(BALL_SZ);
    localparam coord_t C_PAD_W    = coord_t'(PAD_W);
    localparam coord_t C_PAD_H    = coord_t'(PAD_H);
    localparam coord_t C_PAD_Y    = coord_t'(PAD_Y);
    localparam coord_t C_PAD_STEP = coord_t'(PAD_STEP);
    localparam coord_t C_X_MAX    = coord_t'(H_ACT - BALL_SZ);
    localparam coord_t C_PAD_MAX  = coord_t'(H_ACT - PAD_W);
    localparam coord_t C_FLOOR_Y  = coord_t'(PAD_Y - BALL_SZ);
    localparam coord_t C_V_ACT    = coord_t'(V_ACT);

    localparam vel_t V_GRAV = vel_t'(GRAV);
    localparam vel_t V_MAX  = vel_t'(VMAX);
    localparam vel_t V_JUMP = vel_t'(-JUMP_V);

    localparam ball_t BALL_PARK = '{x:  coord_t'((H_ACT - BALL_SZ) / 2),
                                    y:  coord_t'(0),
                                    vx: vel_t'(VX0),
                                    vy: vel_t'(0)};
    localparam coord_t PAD_X0 = coord_t'((H_ACT - PAD_W) / 2);

    // Half-open span test [lo, lo+len), signed.
    function automatic logic in_span(coord_t p, coord_t lo, coord_t len);
        return (p >= lo) && (p < lo + len);
    endfunction

endpackage

// File: rtl/ball_engine_if.sv
// Pixel/timing/button bus between the VGA timing generator (master) and ball_engine (slave).
interface ball_engine_if;
    logic        pix_en;
    logic        frame_tick;
    logic        de;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic        btn_l;
    logic        btn_r;
    logic [11:0] rgb;
    logic [7:0]  score;
    logic [1:0]  state;

    modport master (output pix_en, frame_tick, de, pos_x, pos_y, btn_l, btn_r,
                    input  rgb, score, state);
    modport slave  (input  pix_en, frame_tick, de, pos_x, pos_y, btn_l, btn_r,
                    output rgb, score, state);
endinterface

// File: rtl/ball_engine_btn_sync.sv
// btn_sync: two-flop synchronizer for an async push-button plus a one-clk rising-edge pulse.
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], btn_i};
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/ball_engine.sv
// ball_engine: per-frame ball/paddle physics and registered pixel colour.
// Define SCORE_BAR_EN to draw the score bar across the top rows.
import ball_pkg::*;

module ball_engine (
    input  logic         clk,
    input  logic         rst_n,
    ball_engine_if.slave bus
);
    state_e      state_q, state_d;
    ball_t       ball_q, ball_d;
    coord_t      pad_q, pad_d;
    logic [7:0]  score_q, score_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [11:0] rgb_q, rgb_d;
    logic        lvl_l, lvl_r, rise_l, rise_r;

    btn_sync u_sync_l (.clk(clk), .rst_n(rst_n), .btn_i(bus.btn_l), .level_o(lvl_l), .rise_o(rise_l));
    btn_sync u_sync_r (.clk(clk), .rst_n(rst_n), .btn_i(bus.btn_r), .level_o(lvl_r), .rise_o(rise_r));

    coord_t bx, by, x_n, y_n, pad_n;
    vel_t   vx, vy, vy_n;
    logic signed [6:0] vy_inc;
    logic   floor_w, hit_w;

    assign bx = ball_q.x;
    assign by = ball_q.y;
    assign vx = ball_q.vx;
    assign vy = ball_q.vy;

    // Candidate next-frame geometry, used only while running.
    always_comb begin
        pad_n = pad_q;
        if (lvl_l && !lvl_r)      pad_n = pad_q - C_PAD_STEP;
        else if (lvl_r && !lvl_l) pad_n = pad_q + C_PAD_STEP;
        if (pad_n[10])                pad_n = '0;
        else if (pad_n > C_PAD_MAX)   pad_n = C_PAD_MAX;

        vy_inc  = 7'(vy) + 7'(V_GRAV);
        vy_n    = (vy_inc > 7'(V_MAX)) ? V_MAX : vy_inc[5:0];
        y_n     = by + coord_t'(vy_n);
        x_n     = bx + coord_t'(vx);
        floor_w = (y_n + C_BALL_SZ) >= C_PAD_Y;
        hit_w   = (x_n + C_BALL_SZ > pad_n) && (x_n < pad_n + C_PAD_W);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.frame_tick) begin
            case (state_q)
                ST_IDLE: if (pend_q) state_d = ST_RUN;
                ST_RUN:  if (floor_w && !hit_w) state_d = ST_OVER;
                ST_OVER: if (cnt_q == 7'(OVER_FRAMES - 1)) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ball_d  = ball_q;
        pad_d   = pad_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        // An edge coincident with the tick only arms the start; the tick sees the old flag.
        if (state_q == ST_IDLE && (rise_l || rise_r)) pend_d = 1'b1;
        if (bus.frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    ball_d = BALL_PARK;
                    pad_d  = PAD_X0;
                    if (pend_q) begin
                        pend_d  = 1'b0;
                        score_d = '0;
                    end
                end
                ST_RUN: begin
                    pad_d = pad_n;
                    if (x_n[10]) begin
                        ball_d.x  = '0;
                        ball_d.vx = -vx;
                    end else if (x_n > C_X_MAX) begin
                        ball_d.x  = C_X_MAX;
                        ball_d.vx = -vx;
                    end else begin
                        ball_d.x  = x_n;
                    end
                    ball_d.y  = y_n;
                    ball_d.vy = vy_n;
                    if (y_n[10]) begin
                        ball_d.y  = '0;
                        ball_d.vy = '0;
                    end else if (floor_w && hit_w) begin
                        ball_d.y  = C_FLOOR_Y;
                        ball_d.vy = V_JUMP;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    end else if (floor_w) begin
                        cnt_d = '0;
                    end
                end
                ST_OVER: begin
                    cnt_d = cnt_q + 7'd1;
                    if (state_d == ST_IDLE) begin
                        ball_d = BALL_PARK;
                        pad_d  = PAD_X0;
                    end
                end
                default: ;
            endcase
        end
    end

    coord_t px, py;
    assign px = coord_t'({1'b0, bus.pos_x});
    assign py = coord_t'({2'b00, bus.pos_y});

    // Later assignments take priority: background < bar < paddle < ball < blanking.
    always_comb begin
        rgb_d = (state_q == ST_OVER) ? BG_OVER : BG;
`ifdef SCORE_BAR_EN
        if (py < 11'sd4 && px < coord_t'({2'b00, score_q, 1'b0})) rgb_d = BAR;
`endif
        if (in_span(px, pad_q, C_PAD_W) && in_span(py, C_PAD_Y, C_PAD_H) && py < C_V_ACT) rgb_d = PAD;
        if (in_span(px, bx, C_BALL_SZ) && in_span(py, by, C_BALL_SZ)) rgb_d = BALL;
        if (!bus.de) rgb_d = BG;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ball_q  <= BALL_PARK;
            pad_q   <= PAD_X0;
            score_q <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            rgb_q   <= BG;
        end else begin
            ball_q  <= ball_d;
            pad_q   <= pad_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            if (bus.pix_en) rgb_q <= rgb_d;
        end
    end

    assign bus.rgb   = rgb_q;
    assign bus.score = score_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: directed scenarios plus steered/randomised play
// compared against a frame-level reference model of the game rules.
module tb_ball_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ball_engine_if bus();
    ball_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (plain integers, one update per frame tick).
    int m_state, m_bx, m_by, m_vx, m_vy, m_pad, m_score, m_cnt;
    bit m_pend, m_l, m_r;
    bit saw_hit, saw_clamp;
    logic [11:0] got;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_park();
        m_bx = 314; m_by = 0; m_vx = 3; m_vy = 0; m_pad = 280;
    endfunction

    function automatic void model_reset();
        model_park();
        m_state = 0; m_score = 0; m_cnt = 0; m_pend = 0;
    endfunction

    function automatic void model_tick();
        int xn, yn, vyn;
        case (m_state)
            0: if (m_pend) begin m_state = 1; m_score = 0; m_pend = 0; end
            1: begin
                if (m_l && !m_r) m_pad -= 6;
                if (m_r && !m_l) m_pad += 6;
                if (m_pad < 0) m_pad = 0;
                if (m_pad > 560) m_pad = 560;
                vyn = (m_vy + 1 > 15) ? 15 : m_vy + 1;
                yn = m_by + vyn;
                xn = m_bx + m_vx;
                if (xn < 0)        begin m_bx = 0;   m_vx = -m_vx; end
                else if (xn > 628) begin m_bx = 628; m_vx = -m_vx; end
                else m_bx = xn;
                if (yn < 0) begin m_by = 0; m_vy = 0; end
                else if (yn + 12 >= 460) begin
                    if (xn + 12 > m_pad && xn < m_pad + 80) begin
                        m_by = 448; m_vy = -14;
                        if (m_score < 255) m_score++;
                    end else begin
                        m_by = yn; m_vy = vyn; m_state = 2; m_cnt = 0;
                    end
                end else begin m_by = yn; m_vy = vyn; end
            end
            default: begin
                m_cnt++;
                if (m_cnt == 120) begin m_state = 0; model_park(); end
            end
        endcase
    endfunction

    function automatic logic [11:0] exp_rgb(input int x, input int y, input bit d);
        if (!d) return 12'h000;
        if (x >= m_bx && x < m_bx + 12 && y >= m_by && y < m_by + 12) return 12'hFF0;
        if (x >= m_pad && x < m_pad + 80 && y >= 460 && y < 468) return 12'h0FF;
`ifdef SCORE_BAR_EN
        if (y < 4 && x < m_score * 2) return 12'h0F0;
`endif
        return (m_state == 2) ? 12'h400 : 12'h000;
    endfunction

    task automatic probe(input int x, input int y, input bit d, input string tag, output logic [11:0] o);
        @(negedge clk);
        bus.pos_x = x[9:0]; bus.pos_y = y[8:0]; bus.de = d; bus.pix_en = 1'b1;
        @(negedge clk);
        bus.pix_en = 1'b0;
        o = bus.rgb;
        chk(tag, o, exp_rgb(x, y, d));
    endtask

    task automatic set_btn(input bit l, input bit r);
        @(negedge clk);
        if (m_state == 0 && ((l && !m_l) || (r && !m_r))) m_pend = 1;
        bus.btn_l = l; bus.btn_r = r; m_l = l; m_r = r;
        repeat (4) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        model_tick();
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_state"}, {10'b0, bus.state}, 12'(m_state));
        chk({tag, "_score"}, {4'b0, bus.score}, 12'(m_score));
    endtask

    // One frame of play: steer under the ball, restart when idle, idle when over.
    task automatic frame_step(input bit perturb);
        bit l, r;
        int tgt, px, py;
        logic [11:0] o;
        l = 0; r = 0;
        if (m_state == 1) begin
            tgt = m_bx - 34;
            if (perturb && m_vy < 0 && $urandom_range(15) == 0) begin
                l = 1'($urandom_range(1)); r = 1'($urandom_range(1));
            end else if (m_pad < tgt - 3) r = 1;
            else if (m_pad > tgt + 3) l = 1;
        end else if (m_state == 0 && !m_l && !m_r) r = 1;
        set_btn(l, r);
        tick();
        check_status("frame");
        probe(m_bx, m_by, 1, "ball_tl", o);
        px = m_bx + int'($urandom_range(13)) - 1;
        py = m_by + int'($urandom_range(13)) - 1;
        if (px < 0) px = 0;
        if (px > 639) px = 639;
        if (py < 0) py = 0;
        if (py > 479) py = 479;
        probe(px, py, 1, "ball_edge", o);
        probe(int'($urandom_range(639)), int'($urandom_range(479)), 1'($urandom_range(1)), "rand_pix", o);
    endtask

    task automatic goto_run();
        for (int k = 0; k < 400 && m_state != 1; k++) frame_step(0);
        chk("reach_run", {10'b0, bus.state}, 12'd1);
    endtask

    initial begin
        int hold;
        bus.pix_en = 1'b1; bus.frame_tick = 1'b0; bus.de = 1'b1;
        bus.pos_x = 10'd320; bus.pos_y = 9'd5; bus.btn_l = 1'b0; bus.btn_r = 1'b0;
        m_l = 0; m_r = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", {10'b0, bus.state}, 12'd0);
        chk("rst_score", {4'b0, bus.score}, 12'd0);
        chk("rst_rgb", bus.rgb, 12'h000);
        rst_n = 1'b1;
        bus.pix_en = 1'b0;

        probe(326, 5, 1, "idle_ball_col", got);
        probe(320, 5, 1, "idle_ball", got);      chk("idle_ball_c", got, 12'hFF0);
        probe(320, 465, 1, "idle_pad", got);     chk("idle_pad_c", got, 12'h0FF);
        probe(313, 5, 1, "idle_left_of_ball", got);
        probe(320, 5, 0, "blank", got);          chk("blank_c", got, 12'h000);
        @(negedge clk);
        bus.de = 1'b1; bus.pos_x = 10'd320; bus.pos_y = 9'd5;
        repeat (2) @(negedge clk);
        chk("hold_no_pixen", bus.rgb, 12'h000);

        // Start: button pulse, first tick enters RUN, second moves the ball.
        set_btn(0, 1);
        set_btn(0, 0);
        tick();
        check_status("start");
        chk("start_run_c", {10'b0, bus.state}, 12'd1);
        tick();
        probe(317, 1, 1, "mv_in", got);    chk("mv_in_c", got, 12'hFF0);
        probe(316, 1, 1, "mv_left", got);  chk("mv_left_c", got, 12'h000);
        probe(317, 0, 1, "mv_top", got);   chk("mv_top_c", got, 12'h000);
        probe(328, 12, 1, "mv_br", got);   chk("mv_br_c", got, 12'hFF0);
        probe(329, 12, 1, "mv_out", got);

        // Steered play until a paddle hit and a left-wall paddle clamp have both occurred.
        saw_hit = 0; saw_clamp = 0;
        for (int k = 0; k < 1500 && !(saw_hit && saw_clamp); k++) begin
            frame_step(1);
            if (!saw_hit && m_state == 1 && m_by == 448 && m_vy == -14) begin
                saw_hit = 1;
                probe(m_bx, 448, 1, "hit_ball", got);   chk("hit_ball_c", got, 12'hFF0);
                probe(m_bx, 447, 1, "hit_above", got);  chk("hit_above_c", got, 12'h000);
`ifdef SCORE_BAR_EN
                if (m_score == 1) begin
                    probe(1, 2, 1, "bar", got); chk("bar_c", got, 12'h0F0);
                end
`endif
                frame_step(0);
                if (m_state == 1) begin
                    probe(m_bx, 435, 1, "jump_ball", got); chk("jump_ball_c", got, 12'hFF0);
                    probe(m_bx, 434, 1, "jump_above", got); chk("jump_above_c", got, 12'h000);
                end
            end
            if (!saw_clamp && m_state == 1 && m_pad == 0) begin
                saw_clamp = 1;
                probe(0, 460, 1, "clamp_pad", got);   chk("clamp_pad_c", got, 12'h0FF);
                probe(80, 460, 1, "clamp_edge", got); chk("clamp_edge_c", got, 12'h000);
            end
        end
        chk("saw_hit", {11'b0, saw_hit}, 12'd1);
        chk("saw_clamp", {11'b0, saw_clamp}, 12'd1);

        // Paddle pinned right until the ball is missed, then the OVER countdown.
        goto_run();
        for (int k = 0; k < 400 && m_state != 2; k++) begin
            set_btn(0, 1);
            tick();
            check_status("right");
        end
        chk("over_c", {10'b0, bus.state}, 12'd2);
        probe(100, 100, 1, "over_bg", got); chk("over_bg_c", got, 12'h400);
        hold = m_score;
        set_btn(0, 0);
        for (int k = 0; k < 119; k++) begin
            tick();
            chk("over_wait", {10'b0, bus.state}, 12'(m_state));
        end
        chk("over_wait_c", {10'b0, bus.state}, 12'd2);
        tick();
        chk("over_done_c", {10'b0, bus.state}, 12'd0);
        chk("score_held", {4'b0, bus.score}, 12'(hold));
        probe(320, 5, 1, "repark", got); chk("repark_c", got, 12'hFF0);

        // Button edge landing in the same cycle as frame_tick: arms only.
        @(negedge clk);
        bus.btn_r = 1'b1; m_r = 1;
        @(negedge clk);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        model_tick();
        m_pend = 1;
        chk("coinc_idle", {10'b0, bus.state}, 12'd0);
        repeat (3) @(negedge clk);
        tick();
        chk("coinc_run", {10'b0, bus.state}, 12'd1);

        // Score a hit, then reset in the same cycle as a frame tick.
        for (int k = 0; k < 400 && !(m_state == 1 && m_score >= 1); k++) frame_step(0);
        chk("pre_rst_score", {4'b0, bus.score}, 12'(m_score));
        @(negedge clk);
        rst_n = 1'b0; bus.frame_tick = 1'b1; bus.pix_en = 1'b1; bus.de = 1'b1;
        bus.btn_l = 1'b0; bus.btn_r = 1'b0; m_l = 0; m_r = 0;
        bus.pos_x = m_bx[9:0]; bus.pos_y = m_by[8:0];
        @(negedge clk);
        chk("mrst_state", {10'b0, bus.state}, 12'd0);
        chk("mrst_score", {4'b0, bus.score}, 12'd0);
        chk("mrst_rgb", bus.rgb, 12'h000);
        rst_n = 1'b1; bus.frame_tick = 1'b0; bus.pix_en = 1'b0;
        model_reset();
        probe(320, 5, 1, "mrst_ball", got);  chk("mrst_ball_c", got, 12'hFF0);
        probe(320, 465, 1, "mrst_pad", got); chk("mrst_pad_c", got, 12'h0FF);
        tick();
        check_status("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
